// File: rtl/ppi_pkg.sv
// Shared constants for the clocked PPI: port modes and register address offsets.
package ppi_pkg;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_BOUT = 2'b01;
    localparam logic [1:0] MODE_SIN  = 2'b10;
    localparam logic [1:0] MODE_SOUT = 2'b11;

    // Control/status and INTE registers sit directly above the port data registers.
    localparam int ADDR_CTRL_OFS = 0;
    localparam int ADDR_INTE_OFS = 1;

    function automatic int addr_ctrl(input int num_ports);
        return num_ports + ADDR_CTRL_OFS;
    endfunction

    function automatic int addr_inte(input int num_ports);
        return num_ports + ADDR_INTE_OFS;
    endfunction

endpackage

// File: rtl/ppi_port_channel.sv
// One PPI port: mode, data latch, strobe/ack edge detect, full/overrun flags and INTR.
module ppi_port_channel
    import ppi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_wr,
    input  logic [1:0]        ctrl_mode,
    input  logic              inte_nxt,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    input  logic              ovr_clr,
    input  logic [DATA_W-1:0] port_in,
    input  logic              stb_n,
    input  logic              ack_n,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] port_out,
    output logic              oe,
    output logic              ibf,
    output logic              obf_n,
    output logic              intr,
    output logic              full,
    output logic              ovr
);

    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d, in_q, in_d;
    logic              ibf_q, ibf_d, obf_q, obf_d, ovr_q, ovr_d, intr_q, intr_d;
    logic              stb_prev_q, stb_prev_d, ack_prev_q, ack_prev_d;
    logic              stb_fall, ack_fall;

    always_comb begin
        mode_d     = mode_q;
        data_d     = data_q;
        ibf_d      = ibf_q;
        obf_d      = obf_q;
        ovr_d      = ovr_q & ~ovr_clr;
        in_d       = port_in;
        stb_prev_d = stb_n;
        ack_prev_d = ack_n;
        stb_fall   = stb_prev_q & ~stb_n & (mode_q == MODE_SIN);
        ack_fall   = ack_prev_q & ~ack_n & (mode_q == MODE_SOUT);
        if (ctrl_wr) begin
            mode_d = ctrl_mode;
            data_d = '0;
            ibf_d  = 1'b0;
            obf_d  = 1'b0;
            ovr_d  = 1'b0;
        end else begin
            case (mode_q)
                MODE_BOUT: if (wr) data_d = din;
                MODE_SIN: begin
                    // A read in the same cycle frees the buffer, so the new strobe is not an overrun.
                    if (stb_fall) begin
                        if (ibf_q && !rd) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d = port_in;
                            ibf_d  = 1'b1;
                        end
                    end else if (rd) begin
                        ibf_d = 1'b0;
                    end
                end
                MODE_SOUT: begin
                    if (wr) begin
                        data_d = din;
                        obf_d  = 1'b1;
                        if (obf_q && !ack_fall) ovr_d = 1'b1;
                    end else if (ack_fall) begin
                        obf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        intr_d = inte_nxt & (((mode_d == MODE_SIN) & ibf_d) | ((mode_d == MODE_SOUT) & ~obf_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_BIN;
            data_q     <= '0;
            in_q       <= '0;
            ibf_q      <= 1'b0;
            obf_q      <= 1'b0;
            ovr_q      <= 1'b0;
            intr_q     <= 1'b0;
            stb_prev_q <= 1'b1;
            ack_prev_q <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            data_q     <= data_d;
            in_q       <= in_d;
            ibf_q      <= ibf_d;
            obf_q      <= obf_d;
            ovr_q      <= ovr_d;
            intr_q     <= intr_d;
            stb_prev_q <= stb_prev_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign rd_data  = (mode_q == MODE_BIN) ? in_q : data_q;
    assign oe       = mode_q[0];
    assign port_out = mode_q[0] ? data_q : '0;
    assign ibf      = ibf_q;
    assign obf_n    = ~obf_q;
    assign intr     = intr_q;
    assign full     = ibf_q | obf_q;
    assign ovr      = ovr_q;

endmodule

// File: rtl/ppi_hs_multiport.sv
// Clocked multi-port PPI: host register decode, control/INTE/status registers and read mux.
module ppi_hs_multiport
    import ppi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 3
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        CS_N,
    input  logic                        RD_EN,
    input  logic                        WR_EN,
    input  logic [ADDR_W-1:0]           A,
    input  logic [DATA_W-1:0]           DIN,
    output logic [DATA_W-1:0]           DOUT,
    output logic                        DOUT_VALID,
    input  logic [NUM_PORTS*DATA_W-1:0] PORT_IN,
    output logic [NUM_PORTS*DATA_W-1:0] PORT_OUT,
    output logic [NUM_PORTS-1:0]        PORT_OE,
    input  logic [NUM_PORTS-1:0]        STB_N,
    input  logic [NUM_PORTS-1:0]        ACK_N,
    output logic [NUM_PORTS-1:0]        IBF,
    output logic [NUM_PORTS-1:0]        OBF_N,
    output logic [NUM_PORTS-1:0]        INTR
);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(addr_ctrl(NUM_PORTS));
    localparam logic [ADDR_W-1:0] A_INTE = ADDR_W'(addr_inte(NUM_PORTS));

    logic                              host_wr, host_rd, ctrl_wr, inte_wr, stat_rd;
    logic [NUM_PORTS-1:0]              inte_q, inte_d, ch_full, ch_ovr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  ch_rd_data, ch_out;
    logic [DATA_W-1:0]                 dout_q, dout_d, rd_mux;
    logic                              dout_vld_q, dout_vld_d;

    // Write has priority when both strobes are raised together.
    always_comb begin
        host_wr = ~CS_N & WR_EN;
        host_rd = ~CS_N & RD_EN & ~WR_EN;
        ctrl_wr = host_wr & (A == A_CTRL);
        inte_wr = host_wr & (A == A_INTE);
        stat_rd = host_rd & (A == A_CTRL);
        inte_d  = inte_q;
        if (ctrl_wr)      inte_d = '0;
        else if (inte_wr) inte_d = DIN[NUM_PORTS-1:0];
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ppi_port_channel #(.DATA_W(DATA_W)) u_ch (
            .clk      (CLK),
            .rst      (RESET),
            .ctrl_wr  (ctrl_wr),
            .ctrl_mode(DIN[2*p +: 2]),
            .inte_nxt (inte_d[p]),
            .wr       (host_wr & (A == ADDR_W'(p))),
            .din      (DIN),
            .rd       (host_rd & (A == ADDR_W'(p))),
            .ovr_clr  (stat_rd),
            .port_in  (PORT_IN[p*DATA_W +: DATA_W]),
            .stb_n    (STB_N[p]),
            .ack_n    (ACK_N[p]),
            .rd_data  (ch_rd_data[p]),
            .port_out (ch_out[p]),
            .oe       (PORT_OE[p]),
            .ibf      (IBF[p]),
            .obf_n    (OBF_N[p]),
            .intr     (INTR[p]),
            .full     (ch_full[p]),
            .ovr      (ch_ovr[p])
        );
        assign PORT_OUT[p*DATA_W +: DATA_W] = ch_out[p];
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (A == ADDR_W'(p)) rd_mux = ch_rd_data[p];
        end
        if (A == A_CTRL) begin
            rd_mux[NUM_PORTS-1:0]           = ch_full;
            rd_mux[2*NUM_PORTS-1:NUM_PORTS] = ch_ovr;
        end else if (A == A_INTE) begin
            rd_mux[NUM_PORTS-1:0] = inte_q;
        end
        dout_d     = host_rd ? rd_mux : dout_q;
        dout_vld_d = host_rd;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inte_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            inte_q     <= inte_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_vld_q;

endmodule

// File: tb/tb_ppi_hs_multiport.sv
// Randomized scoreboard bench for ppi_hs_multiport with a cycle-level behavioural model.
module tb_ppi_hs_multiport;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int AW = 3;

    logic             CLK = 1'b0;
    logic             RESET, CS_N, RD_EN, WR_EN;
    logic [AW-1:0]    A;
    logic [DW-1:0]    DIN, DOUT;
    logic             DOUT_VALID;
    logic [NP*DW-1:0] PORT_IN, PORT_OUT;
    logic [NP-1:0]    PORT_OE, STB_N, ACK_N, IBF, OBF_N, INTR;

    always #5 CLK = ~CLK;

    ppi_hs_multiport #(.DATA_W(DW), .NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .RD_EN(RD_EN), .WR_EN(WR_EN), .A(A), .DIN(DIN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT),
        .PORT_OE(PORT_OE), .STB_N(STB_N), .ACK_N(ACK_N), .IBF(IBF), .OBF_N(OBF_N), .INTR(INTR)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    // Reference state, kept as plain per-port arrays.
    logic [1:0]    m_mode[NP];
    logic [DW-1:0] m_latch[NP];
    logic [DW-1:0] m_inq[NP];
    bit            m_ibf[NP], m_obf[NP], m_ovr[NP], m_sp[NP], m_ap[NP];
    logic [NP-1:0] m_inte;

    logic [NP*DW-1:0] pin_cur;
    logic [NP-1:0]    stb_cur, ack_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (DOUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dout_unexpected: got valid with data %0h, required no read pending", DOUT);
            end else begin
                chk("dout", 64'(DOUT), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mode[p] = 2'b00; m_latch[p] = '0; m_inq[p] = '0;
            m_ibf[p] = 0; m_obf[p] = 0; m_ovr[p] = 0; m_sp[p] = 1; m_ap[p] = 1;
        end
        m_inte = '0;
    endtask

    function automatic logic [DW-1:0] model_read(input int ai);
        logic [DW-1:0] v = '0;
        if (ai < NP) begin
            v = (m_mode[ai] == 2'b00) ? m_inq[ai] : m_latch[ai];
        end else if (ai == NP) begin
            for (int p = 0; p < NP; p++) begin
                v[p]      = m_ibf[p] | m_obf[p];
                v[NP + p] = m_ovr[p];
            end
        end else if (ai == NP + 1) begin
            v[NP-1:0] = m_inte;
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic [NP-1:0] e_oe, e_ibf, e_obfn, e_intr;
        for (int p = 0; p < NP; p++) begin
            e_oe[p]   = (m_mode[p] == 2'b01) || (m_mode[p] == 2'b11);
            e_ibf[p]  = m_ibf[p];
            e_obfn[p] = !m_obf[p];
            e_intr[p] = m_inte[p] && ((m_mode[p] == 2'b10 && m_ibf[p]) || (m_mode[p] == 2'b11 && !m_obf[p]));
            if (e_oe[p]) chk("port_out", 64'(PORT_OUT[p*DW +: DW]), 64'(m_latch[p]));
        end
        chk("port_oe", 64'(PORT_OE), 64'(e_oe));
        chk("ibf", 64'(IBF), 64'(e_ibf));
        chk("obf_n", 64'(OBF_N), 64'(e_obfn));
        chk("intr", 64'(INTR), 64'(e_intr));
    endtask

    // Drive one clock cycle of stimulus, advance the model, then check flag outputs after the edge.
    task automatic cycle(input bit rst, input bit cs_n, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] din, input logic [NP*DW-1:0] pin,
                         input logic [NP-1:0] stb, input logic [NP-1:0] ack);
        bit hw, hr, sf, af, pw, pr;
        int ai;
        RESET = rst; CS_N = cs_n; RD_EN = rd; WR_EN = wr; A = a; DIN = din;
        PORT_IN = pin; STB_N = stb; ACK_N = ack;
        hw = !cs_n && wr;
        hr = !cs_n && rd && !wr;
        ai = int'(a);
        if (rst) begin
            model_reset();
        end else begin
            if (hr) exp_q.push_back(model_read(ai));
            if (hw && ai == NP) begin
                for (int p = 0; p < NP; p++) begin
                    m_mode[p] = din[2*p +: 2]; m_latch[p] = '0;
                    m_ibf[p] = 0; m_obf[p] = 0; m_ovr[p] = 0;
                end
                m_inte = '0;
            end else begin
                if (hr && ai == NP) for (int p = 0; p < NP; p++) m_ovr[p] = 0;
                if (hw && ai == NP + 1) m_inte = din[NP-1:0];
                for (int p = 0; p < NP; p++) begin
                    sf = m_sp[p] && !stb[p] && m_mode[p] == 2'b10;
                    af = m_ap[p] && !ack[p] && m_mode[p] == 2'b11;
                    pw = hw && ai == p;
                    pr = hr && ai == p;
                    if (m_mode[p] == 2'b01 && pw) m_latch[p] = din;
                    if (m_mode[p] == 2'b10) begin
                        if (pr) m_ibf[p] = 0;
                        if (sf) begin
                            if (m_ibf[p]) m_ovr[p] = 1;
                            else begin m_latch[p] = pin[p*DW +: DW]; m_ibf[p] = 1; end
                        end
                    end
                    if (m_mode[p] == 2'b11) begin
                        if (af) m_obf[p] = 0;
                        if (pw) begin
                            if (m_obf[p]) m_ovr[p] = 1;
                            m_latch[p] = din;
                            m_obf[p] = 1;
                        end
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                m_inq[p] = pin[p*DW +: DW];
                m_sp[p]  = stb[p];
                m_ap[p]  = ack[p];
            end
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 1, 0, 0, '0, '0, pin_cur, stb_cur, ack_cur);
    endtask
    task automatic wr_reg(input int a, input logic [DW-1:0] d);
        cycle(0, 0, 0, 1, AW'(a), d, pin_cur, stb_cur, ack_cur);
    endtask
    task automatic rd_reg(input int a);
        cycle(0, 0, 1, 0, AW'(a), '0, pin_cur, stb_cur, ack_cur);
    endtask

    initial begin
        bit rst, cs_n, rd, wr;
        logic [AW-1:0] a;
        pin_cur = '0; stb_cur = '1; ack_cur = '1;
        model_reset();
        cycle(1, 1, 0, 0, '0, '0, pin_cur, stb_cur, ack_cur);
        cycle(1, 1, 0, 0, '0, '0, pin_cur, stb_cur, ack_cur);
        chk("rst_obf_n", 64'(OBF_N), 64'(4'hF));
        chk("rst_oe", 64'(PORT_OE), 64'(4'h0));
        chk("rst_intr", 64'(INTR), 64'(4'h0));
        chk("rst_dout_valid", 64'(DOUT_VALID), 64'(1'b0));
        rd_reg(4);
        chk("rst_status", 64'(DOUT), 64'(8'h00));

        // Modes: p3 strobed out, p2 strobed in, p1 basic out, p0 basic in.
        wr_reg(4, 8'b11_10_01_00);
        wr_reg(1, 8'h5A);
        chk("oe_modes", 64'(PORT_OE), 64'(4'b1010));
        chk("port1_out", 64'(PORT_OUT[15:8]), 64'(8'h5A));
        pin_cur[7:0] = 8'hA5;
        rd_reg(0);
        rd_reg(0);
        chk("port0_in", 64'(DOUT), 64'(8'hA5));

        pin_cur[23:16] = 8'h3C; idle();
        stb_cur[2] = 0; idle();
        stb_cur[2] = 1; idle();
        pin_cur[23:16] = 8'hC3; idle();
        stb_cur[2] = 0; idle();
        stb_cur[2] = 1; idle();
        chk("p2_ibf_set", 64'(IBF[2]), 64'(1'b1));
        rd_reg(4);
        chk("p2_status_ovr", 64'(DOUT), 64'(8'h44));
        rd_reg(2);
        chk("p2_data", 64'(DOUT), 64'(8'h3C));
        chk("p2_ibf_clr", 64'(IBF[2]), 64'(1'b0));
        rd_reg(4);
        chk("status_cleared", 64'(DOUT), 64'(8'h00));

        wr_reg(5, 8'h08);
        wr_reg(3, 8'h77);
        chk("p3_obf", 64'(OBF_N[3]), 64'(1'b0));
        chk("p3_intr_lo", 64'(INTR[3]), 64'(1'b0));
        wr_reg(3, 8'h88);
        rd_reg(4);
        chk("p3_status_ovr", 64'(DOUT), 64'(8'h88));
        ack_cur[3] = 0; idle();
        ack_cur[3] = 1; idle();
        chk("p3_obf_clr", 64'(OBF_N[3]), 64'(1'b1));
        chk("p3_intr_hi", 64'(INTR[3]), 64'(1'b1));
        chk("p3_out", 64'(PORT_OUT[31:24]), 64'(8'h88));

        pin_cur[23:16] = 8'h11; idle();
        stb_cur[2] = 0; idle();
        stb_cur[2] = 1; pin_cur[23:16] = 8'h22; idle();
        stb_cur[2] = 0;
        rd_reg(2);
        chk("rd_stb_old", 64'(DOUT), 64'(8'h11));
        chk("rd_stb_ibf", 64'(IBF[2]), 64'(1'b1));
        stb_cur[2] = 1;
        rd_reg(4);
        chk("rd_stb_noovr", 64'(DOUT), 64'(8'h04));
        wr_reg(3, 8'h99);
        ack_cur[3] = 0;
        wr_reg(3, 8'hAA);
        chk("wr_ack_obf", 64'(OBF_N[3]), 64'(1'b0));
        ack_cur[3] = 1;
        rd_reg(4);
        chk("wr_ack_noovr", 64'(DOUT), 64'(8'h0C));

        cycle(0, 0, 1, 1, 3'd5, 8'h0F, pin_cur, stb_cur, ack_cur);
        cycle(0, 1, 0, 1, 3'd4, 8'hFF, pin_cur, stb_cur, ack_cur);
        cycle(1, 1, 0, 0, '0, '0, pin_cur, stb_cur, ack_cur);
        chk("mid_rst_ibf", 64'(IBF), 64'(4'h0));
        chk("mid_rst_obf_n", 64'(OBF_N), 64'(4'hF));
        chk("mid_rst_out", 64'(PORT_OUT), 64'(32'h0));
        chk("mid_rst_dout", 64'(DOUT), 64'(8'h00));
        wr_reg(7, 8'hFF);
        chk("a7_oe", 64'(PORT_OE), 64'(4'h0));
        rd_reg(7);
        chk("a7_read", 64'(DOUT), 64'(8'h00));

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            cs_n = ($urandom_range(0, 9) == 0);
            rd   = $urandom_range(0, 1);
            wr   = $urandom_range(0, 1);
            a    = AW'($urandom_range(0, 7));
            if (wr && a == AW'(NP) && $urandom_range(0, 9) != 0) a = AW'($urandom_range(0, NP - 1));
            if ($urandom_range(0, 3) == 0) pin_cur = $urandom;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0) stb_cur[p] = ~stb_cur[p];
                if ($urandom_range(0, 3) == 0) ack_cur[p] = ~ack_cur[p];
            end
            cycle(rst, cs_n, rd, wr, a, DW'($urandom), pin_cur, stb_cur, ack_cur);
        end
        idle();
        idle();
        chk("dout_pending", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
